// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: bundles the operand input stream, the ALU-facing
// registered operands / returned result+flags, and the response stream.
//   master : upstream/testbench side (drives beats, ALU result, out_ready)
//   slave  : the sequencer side
interface alu_op_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  // operand stream
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_op;
  logic             in_chain;
  // ALU side
  logic [WIDTH-1:0] alu_num1;
  logic [WIDTH-1:0] alu_num2;
  logic [1:0]       alu_opcode;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry_out;
  logic             alu_overflow;
  logic             alu_negative;
  logic             alu_zero;
  // response stream
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [3:0]       out_flags;
  logic [CNT_W-1:0] ops_count;
  logic             busy;

  modport master (
    output in_valid, in_data, in_op, in_chain,
    output alu_result, alu_carry_out, alu_overflow, alu_negative, alu_zero,
    output out_ready,
    input  in_ready, alu_num1, alu_num2, alu_opcode,
    input  out_valid, out_result, out_flags, ops_count, busy
  );

  modport slave (
    input  in_valid, in_data, in_op, in_chain,
    input  alu_result, alu_carry_out, alu_overflow, alu_negative, alu_zero,
    input  out_ready,
    output in_ready, alu_num1, alu_num2, alu_opcode,
    output out_valid, out_result, out_flags, ops_count, busy
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: collects A then B operand beats, holds them stable on the
// ALU inputs, captures the ALU result/flags one cycle later and offers them on
// a valid/ready response stream. Chained ops feed the result back as next A.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - alu_op_sequencer_if.slave (operand stream, ALU link, response
//          stream, ops_count, busy)
module alu_op_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  alu_op_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    WAIT_A = 2'd0,
    WAIT_B = 2'd1,
    EXEC   = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [1:0]       op_q;
  logic             chain_q;
  logic [3:0]       flags_q;
  logic [CNT_W-1:0] cnt_q;

  logic in_ready, out_valid, busy;
  logic in_fire, out_fire;

  assign in_fire  = bus.in_valid  & in_ready;
  assign out_fire = out_valid     & bus.out_ready;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= WAIT_A;
    else     state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_A: if (in_fire)  state_d = WAIT_B;
      WAIT_B: if (in_fire)  state_d = EXEC;
      EXEC:                 state_d = RESP;
      RESP:   if (out_fire) state_d = chain_q ? WAIT_B : WAIT_A;
      default:              state_d = WAIT_A;
    endcase
  end

  // outputs; ready is masked by rst so nothing is offered while reset is held
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      WAIT_A: begin in_ready = ~rst; busy = 1'b0; end
      WAIT_B: in_ready  = ~rst;
      RESP:   out_valid = 1'b1;
      default: ;
    endcase
  end

  // datapath; operands move only on capture edges so the ALU sees stable
  // inputs through EXEC and RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      chain_q <= 1'b0;
      res_q   <= '0;
      flags_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        WAIT_A: if (in_fire) a_q <= bus.in_data;
        WAIT_B: if (in_fire) begin
          b_q     <= bus.in_data;
          op_q    <= bus.in_op;
          chain_q <= bus.in_chain;
        end
        EXEC: begin
          res_q   <= bus.alu_result;
          flags_q <= {bus.alu_negative, bus.alu_zero, bus.alu_carry_out, bus.alu_overflow};
        end
        RESP: if (out_fire) begin
          if (chain_q) a_q <= res_q;
          if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.busy       = busy;
  assign bus.alu_num1   = a_q;
  assign bus.alu_num2   = b_q;
  assign bus.alu_opcode = op_q;
  assign bus.out_result = res_q;
  assign bus.out_flags  = flags_q;
  assign bus.ops_count  = cnt_q;

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Operand sequencer and result capture stage wrapped around the team's 4-bit combinational `ALU`. It accepts operands one beat at a time over a valid/ready stream and drives the ALU's `num1`/`num2`/`opcode` from stable registers. It registers the ALU's `result` and its four flags, then presents them on a valid/ready output stream. It supports chained operation, where the previous result becomes the next first operand, and it keeps a saturating completed-operation counter.

## Interface
- `WIDTH`, 4: operand/result width; must match the ALU.
- `CNT_W`, 8: width of `ops_count`.

- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: operand beat valid.
- `in_ready` out 1: sequencer accepts a beat; transfer when `in_valid && in_ready` at a rising edge.
- `in_data` in WIDTH: operand value.
- `in_op` in 2: ALU opcode (00 add, 01 sub, 10 OR, 11 AND); sampled on the B beat only.
- `in_chain` in 1: sampled on the B beat; 1 = reuse the result as the next A.
- `alu_num1` out WIDTH: registered A to the ALU `num1`.
- `alu_num2` out WIDTH: registered B to the ALU `num2`.
- `alu_opcode` out 2: registered opcode to the ALU `opcode`.
- `alu_result` in WIDTH: from the ALU `result`.
- `alu_carry_out`, `alu_overflow`, `alu_negative`, `alu_zero` in 1 each: ALU flags.
- `out_valid` out 1: response valid.
- `out_ready` in 1: consumer accepts; transfer when `out_valid && out_ready` at a rising edge.
- `out_result` out WIDTH: captured result.
- `out_flags` out 4: captured flags, packed {negative, zero, carry_out, overflow}.
- `ops_count` out CNT_W: completed responses, saturating.
- `busy` out 1: high in any state other than WAIT_A.

## Operation
- FSM states: WAIT_A, WAIT_B, EXEC, RESP.
- WAIT_A:
  - `in_ready`=1.
  - On transfer: A ← `in_data`, then go to WAIT_B.
- WAIT_B:
  - `in_ready`=1.
  - On transfer: B ← `in_data`, opcode ← `in_op`, chain_r ← `in_chain`, then go to EXEC.
- EXEC:
  - `in_ready`=0, for exactly one cycle.
  - At the closing edge: `out_result` ← `alu_result`, `out_flags` ← {flags}.
  - Go to RESP.
- RESP:
  - `out_valid`=1, `in_ready`=0.
  - Outputs hold stable until the out transfer; no timeout.
  - On out transfer with chain_r=1: A ← `out_result`, go to WAIT_B.
  - On out transfer with chain_r=0: go to WAIT_A.
  - `ops_count` ← `ops_count`+1 on every out transfer, saturating at 2^CNT_W−1.
- `alu_num1`/`alu_num2`/`alu_opcode` change only on the A/B capture edges. They stay stable throughout EXEC and RESP.
- The sequencer does no arithmetic; flags are passed through exactly as the ALU produces them.
- `in_op`/`in_chain` are ignored on the A beat.

## Timing
- Reset (async assert, synchronous-safe release):
  - State is WAIT_A.
  - A, B, opcode, chain_r, `out_result`, `out_flags`, `ops_count` are all 0.
  - `out_valid`=0, `busy`=0.
  - `in_ready`=0 while `rst` is high, 1 from the first cycle after release.
- Latency: B accepted at edge t → `out_valid`=1 after edge t+1. A→B→response minimum is 3 edges.
- Back-to-back throughput, with `out_ready` held 1:
  - Unchained: 1 op per 4 cycles.
  - Chained: 1 op per 3 cycles.
- `rst` asserted mid-operation: the in-flight op is dropped immediately. `out_valid` falls asynchronously and no count increment occurs.
- `in_valid` without a transfer (EXEC/RESP): the beat is not consumed; the upstream must hold it.
- `out_ready` high while `out_valid`=0 has no effect.

## Test plan
- Reset, then A=0001, B=0010, op=00, `out_ready`=1 → `out_valid` one cycle after B, `out_result`=0011, `out_flags`=0000, `ops_count`=1.
- A=1100, B=1010, op=10, then A=1100, B=1010, op=11 → results 1110 (flags 1000) then 1000 (flags 1000). `alu_num1`/`alu_num2`/`alu_opcode` are stable during RESP.
- A=1111, B=0001, op=00 → `out_result`=0000, `out_flags`=0110 (Z, C set).
- Chain: A=0001, B=0001, op=00, chain=1, then B=0010, op=00, chain=0 → 0010 then 0100. No second A beat is accepted; `in_ready`=1 in WAIT_B directly after the first response.
- Backpressure: hold `out_ready`=0 for 5 cycles in RESP with `in_valid`=1 → `in_ready`=0 and outputs are constant. Release → exactly one transfer.
- Assert `rst` during EXEC and during RESP → outputs go to reset values immediately and `ops_count` is unchanged from 0. Force `ops_count` to 255 via 255 ops → the next op leaves it at 255.
